// File: rtl/alu_pkg.sv
// Shared opcodes, ALU control codes and FSM states for the ALU issue stage.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDI = 4'b0001;
  localparam logic [3:0] ALU_LSL  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpAddi = 3'd1,
    OpLsl  = 3'd2,
    OpSub  = 3'd3,
    OpLdur = 3'd4,
    OpStur = 3'd5,
    OpCbz  = 3'd6
  } issue_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StMem  = 2'd2,
    StDone = 2'd3
  } issue_state_t;

  // Loads and stores take the extra MEM cycle.
  function automatic logic is_mem_op(logic [2:0] op);
    return (op == OpLdur) || (op == OpStur);
  endfunction

  // Encodings past CBZ have no defined behaviour and complete with an error.
  function automatic logic is_undef_op(logic [2:0] op);
    return op > OpCbz;
  endfunction

endpackage

// File: rtl/x_regfile.sv
// 32-entry X register file: three combinational read ports, a debug read port,
// one synchronous write port. X31 reads as zero and ignores writes.
module x_regfile #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [4:0]        rn_addr_i,
  output logic [DATA_W-1:0] rn_data_o,
  input  logic [4:0]        rm_addr_i,
  output logic [DATA_W-1:0] rm_data_o,
  input  logic [4:0]        rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] x_q [32];

  // Register array: async clear, single write port, X31 never written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) x_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd31)) begin
      x_q[waddr_i] <= wdata_i;
    end
  end

  assign rn_data_o  = (rn_addr_i  == 5'd31) ? '0 : x_q[rn_addr_i];
  assign rm_data_o  = (rm_addr_i  == 5'd31) ? '0 : x_q[rm_addr_i];
  assign rd_data_o  = (rd_addr_i  == 5'd31) ? '0 : x_q[rd_addr_i];
  assign dbg_data_o = (dbg_addr_i == 5'd31) ? '0 : x_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage in front of the ALU and data memory: latches one micro-op per
// handshake, reads operands in EXEC, writes back ALU or load data, reports done.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        in_op_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rn_i,
  input  logic [4:0]        in_rm_i,
  input  logic [DATA_W-1:0] in_imm_i,
  output logic [3:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [DATA_W-1:0] alu_imm_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              done_valid_o,
  output logic              done_err_o,
  output logic              branch_taken_o,
  input  logic [4:0]        dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  issue_state_t      state_q, state_d;
  logic [2:0]        op_q;
  logic [4:0]        rd_q, rn_q, rm_q;
  logic [DATA_W-1:0] imm_q;

  logic              in_ready_q, in_ready_d;
  logic              done_valid_q, done_valid_d;
  logic              done_err_q, done_err_d;
  logic              branch_q, branch_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] alu_imm_q, alu_imm_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [DATA_W-1:0] rf_rn, rf_rm, rf_rd, rf_wdata;
  logic              rf_we;
  logic              accept;

  // in_ready_q is only ever high in IDLE, so it alone qualifies the handshake.
  assign accept = in_valid_i && in_ready_q;

  x_regfile #(
    .DATA_W (DATA_W)
  ) u_x_regfile (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rn_addr_i  (rn_q),
    .rn_data_o  (rf_rn),
    .rm_addr_i  (rm_q),
    .rm_data_o  (rf_rm),
    .rd_addr_i  (rd_q),
    .rd_data_o  (rf_rd),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (rf_wdata),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  // Next state, operand muxing, writeback selection and memory request.
  always_comb begin
    state_d     = state_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_imm_d   = alu_imm_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_we       = 1'b0;
    rf_wdata    = alu_result_i;

    case (state_q)
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        state_d = is_mem_op(op_q) ? StMem : StDone;
        case (op_q)
          OpAdd: begin
            alu_op_d = ALU_ADD;
            alu_a_d  = rf_rn;
            alu_b_d  = rf_rm;
            rf_we    = 1'b1;
          end
          OpSub: begin
            alu_op_d = ALU_SUB;
            alu_a_d  = rf_rn;
            alu_b_d  = rf_rm;
            rf_we    = 1'b1;
          end
          OpAddi: begin
            alu_op_d  = ALU_ADDI;
            alu_a_d   = rf_rn;
            alu_imm_d = imm_q;
            rf_we     = 1'b1;
          end
          OpLsl: begin
            alu_op_d = ALU_LSL;
            alu_a_d  = rf_rn;
            alu_b_d  = imm_q;
            rf_we    = 1'b1;
          end
          OpLdur, OpStur: begin
            // ALU forms the byte address; it is held for the MEM cycle.
            alu_op_d   = ALU_ADDI;
            alu_a_d    = rf_rn;
            alu_imm_d  = imm_q;
            mem_addr_d = alu_result_i;
            if (op_q == OpStur) mem_wdata_d = rf_rd;
          end
          default: ;  // CBZ and undefined ops leave the ALU inputs untouched
        endcase
      end
      StMem: begin
        state_d = StDone;
        if (op_q == OpLdur) begin
          rf_we    = 1'b1;
          rf_wdata = mem_rdata_i;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered status flags, all derived from the state being entered.
  always_comb begin
    in_ready_d   = (state_d == StIdle);
    done_valid_d = (state_d == StDone);
    done_err_d   = (state_d == StDone) && is_undef_op(op_q);
    branch_d     = (state_d == StDone) && (state_q == StExec) && (op_q == OpCbz) &&
                   (rf_rd == '0);
    mem_we_d     = (state_q == StExec) && (op_q == OpStur);
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      op_q         <= '0;
      rd_q         <= '0;
      rn_q         <= '0;
      rm_q         <= '0;
      imm_q        <= '0;
      in_ready_q   <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      branch_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_imm_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
      branch_q     <= branch_d;
      mem_we_q     <= mem_we_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_imm_q    <= alu_imm_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if (accept) begin
        op_q  <= in_op_i;
        rd_q  <= in_rd_i;
        rn_q  <= in_rn_i;
        rm_q  <= in_rm_i;
        imm_q <= in_imm_i;
      end
    end
  end

  // ALU inputs follow the EXEC operand mux combinationally so the result is
  // available for writeback in the same cycle; they hold elsewhere.
  assign alu_op_o       = alu_op_d;
  assign alu_a_o        = alu_a_d;
  assign alu_b_o        = alu_b_d;
  assign alu_imm_o      = alu_imm_d;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign mem_we_o       = mem_we_q;
  assign in_ready_o     = in_ready_q;
  assign done_valid_o   = done_valid_q;
  assign done_err_o     = done_err_q;
  assign branch_taken_o = branch_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU and memory around the DUT, a
// table of directed vectors, a reset-during-store sequence and random ops
// checked against an architectural model of the X registers and memory.
module tb_alu_issue_unit;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd, in_rn, in_rm, dbg_addr;
  logic [31:0] in_imm, alu_a, alu_b, alu_imm, alu_result;
  logic [3:0]  alu_op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_data;
  logic        mem_we, done_valid, done_err, branch_taken;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_unit #(
    .DATA_W (32)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_op_i        (in_op),
    .in_rd_i        (in_rd),
    .in_rn_i        (in_rn),
    .in_rm_i        (in_rm),
    .in_imm_i       (in_imm),
    .alu_op_o       (alu_op),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .alu_imm_o      (alu_imm),
    .alu_result_i   (alu_result),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_we_o       (mem_we),
    .mem_rdata_i    (mem_rdata),
    .done_valid_o   (done_valid),
    .done_err_o     (done_err),
    .branch_taken_o (branch_taken),
    .dbg_addr_i     (dbg_addr),
    .dbg_data_o     (dbg_data)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Behavioural ALU.
  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a + alu_imm;
      4'd2:    alu_result = alu_a << alu_b;
      4'd3:    alu_result = alu_a - alu_b;
      default: alu_result = 32'h0;
    endcase
  end

  // Behavioural memory, 256 byte-addressed words (low address byte only).
  logic [31:0] env_mem [256];
  assign mem_rdata = env_mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;

  // Architectural reference model.
  logic [31:0] mdl_x   [32];
  logic [31:0] mdl_mem [256];
  logic [3:0]  mdl_alu_op;

  function automatic logic [31:0] xr(input int i);
    return (i == 31) ? 32'h0 : mdl_x[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sweep_regs();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("x%0d", i), dbg_data, xr(i));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl_x[i] = 32'h0;
    mdl_alu_op = 4'h0;
  endtask

  // Issue one micro-op, observe it to completion, check against the model.
  task automatic run_instr(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [31:0] imm, input logic hold,
                           output int lat, output logic err, output logic br);
    logic [31:0] a, b, t, res, addr, eb, eimm;
    logic [3:0]  aop;
    logic        uses_alu, is_mem, wr, chk_b, chk_imm, exp_br;
    int          k, n, we_cnt;
    a = xr(rn); b = xr(rm); t = xr(rd);
    res = 0; addr = 0; aop = 0; eb = 0; eimm = 0;
    chk_b = 0; chk_imm = 0; wr = 0;
    uses_alu = (op <= 3'd5);
    is_mem   = (op == 3'd4) || (op == 3'd5);
    exp_br   = (op == 3'd6) && (t == 0);
    case (op)
      3'd0: begin aop = 4'd0; res = a + b;   eb = b;     chk_b = 1;   wr = 1; end
      3'd1: begin aop = 4'd1; res = a + imm; eimm = imm; chk_imm = 1; wr = 1; end
      3'd2: begin aop = 4'd2; res = a << imm; eb = imm;  chk_b = 1;   wr = 1; end
      3'd3: begin aop = 4'd3; res = a - b;   eb = b;     chk_b = 1;   wr = 1; end
      3'd4: begin aop = 4'd1; addr = a + imm; eimm = imm; chk_imm = 1; wr = 1; end
      3'd5: begin aop = 4'd1; addr = a + imm; eimm = imm; chk_imm = 1; end
      default: ;
    endcase
    if (op == 3'd4) res = mdl_mem[addr[7:0]];

    @(negedge clk);
    k = 0;
    while (in_ready !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    if (k >= 10) check("in_ready_wait", {31'h0, in_ready}, 32'h1);
    in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;

    n = 0; lat = 99; err = 1'bx; br = 1'bx; we_cnt = 0;
    while (lat == 99 && n < 6) begin
      @(negedge clk);
      n++;
      check("busy_in_ready", {31'h0, in_ready}, 32'h0);
      if (mem_we === 1'b1) begin
        we_cnt++;
        check("st_addr", mem_addr, addr);
        check("st_wdata", mem_wdata, t);
      end
      if (n == 1) begin
        if (uses_alu) begin
          check("exec_alu_op", {28'h0, alu_op}, {28'h0, aop});
          check("exec_alu_a", alu_a, a);
          if (chk_b) check("exec_alu_b", alu_b, eb);
          if (chk_imm) check("exec_alu_imm", alu_imm, eimm);
        end else begin
          check("hold_alu_op", {28'h0, alu_op}, {28'h0, mdl_alu_op});
        end
      end
      if (n == 2 && is_mem) check("mem_addr", mem_addr, addr);
      if (done_valid === 1'b1) begin
        lat = n; err = done_err; br = branch_taken;
      end
    end
    in_valid = 1'b0;
    check("latency", lat, is_mem ? 3 : 2);
    check("done_err", {31'h0, err}, {31'h0, (op == 3'd7)});
    check("branch", {31'h0, br}, {31'h0, exp_br});
    check("we_pulses", we_cnt, (op == 3'd5) ? 1 : 0);

    if (wr && rd != 5'd31) mdl_x[rd] = res;
    if (op == 3'd5) mdl_mem[addr[7:0]] = t;
    if (uses_alu) mdl_alu_op = aop;

    @(negedge clk);
    check("idle_done", {31'h0, done_valid}, 32'h0);
    check("idle_err", {31'h0, done_err}, 32'h0);
    check("idle_br", {31'h0, branch_taken}, 32'h0);
    check("idle_ready", {31'h0, in_ready}, 32'h1);
    check("idle_we", {31'h0, mem_we}, 32'h0);
    sweep_regs();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [31:0] imm;
    logic [4:0]  chk_reg;
    logic [31:0] chk_val;
    logic        exp_br;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl [13];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat;
    logic err, br;

    tbl[0]  = '{3'd1, 5'd6,  5'd31, 5'd0,  32'd20,   5'd6,  32'd20,        1'b0, 1'b0, 2};
    tbl[1]  = '{3'd0, 5'd5,  5'd31, 5'd31, 32'd0,    5'd5,  32'd0,         1'b0, 1'b0, 2};
    tbl[2]  = '{3'd1, 5'd5,  5'd31, 5'd0,  32'd3,    5'd5,  32'd3,         1'b0, 1'b0, 2};
    tbl[3]  = '{3'd2, 5'd10, 5'd5,  5'd0,  32'd3,    5'd10, 32'd24,        1'b0, 1'b0, 2};
    tbl[4]  = '{3'd3, 5'd14, 5'd31, 5'd10, 32'd0,    5'd14, 32'hFFFFFFE8,  1'b0, 1'b0, 2};
    tbl[5]  = '{3'd1, 5'd15, 5'd31, 5'd0,  32'h40,   5'd15, 32'h40,        1'b0, 1'b0, 2};
    tbl[6]  = '{3'd5, 5'd14, 5'd15, 5'd0,  32'd0,    5'd14, 32'hFFFFFFE8,  1'b0, 1'b0, 3};
    tbl[7]  = '{3'd4, 5'd12, 5'd15, 5'd0,  32'd0,    5'd12, 32'hFFFFFFE8,  1'b0, 1'b0, 3};
    tbl[8]  = '{3'd6, 5'd16, 5'd0,  5'd0,  32'd0,    5'd16, 32'd0,         1'b1, 1'b0, 2};
    tbl[9]  = '{3'd1, 5'd16, 5'd31, 5'd0,  32'd5,    5'd16, 32'd5,         1'b0, 1'b0, 2};
    tbl[10] = '{3'd6, 5'd16, 5'd0,  5'd0,  32'd0,    5'd16, 32'd5,         1'b0, 1'b0, 2};
    tbl[11] = '{3'd1, 5'd31, 5'd31, 5'd0,  32'd7,    5'd31, 32'd0,         1'b0, 1'b0, 2};
    tbl[12] = '{3'd7, 5'd6,  5'd5,  5'd10, 32'd99,   5'd6,  32'd20,        1'b0, 1'b1, 2};

    for (int i = 0; i < 256; i++) begin
      env_mem[i] = {4{8'(i)}} ^ 32'hC3A51E0F;
      mdl_mem[i] = {4{8'(i)}} ^ 32'hC3A51E0F;
    end
    model_reset();

    rst_n = 1'b0; in_valid = 1'b0; in_op = 0; in_rd = 0; in_rn = 0; in_rm = 0;
    in_imm = 0; dbg_addr = 5'd0;
    #3;
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_done", {31'h0, done_valid}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_alu_op", {28'h0, alu_op}, 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed table; odd entries hold in_valid high until DONE.
    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].op, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].imm, i[0], lat, err, br);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      check($sformatf("tbl%0d_err", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
      check($sformatf("tbl%0d_br", i), {31'h0, br}, {31'h0, tbl[i].exp_br});
      dbg_addr = tbl[i].chk_reg;
      #1;
      check($sformatf("tbl%0d_reg", i), dbg_data, tbl[i].chk_val);
    end

    // Asynchronous reset in the MEM cycle of a store.
    @(negedge clk);
    in_op = 3'd5; in_rd = 5'd14; in_rn = 5'd15; in_rm = 5'd0; in_imm = 32'd8; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stur_mem_we", {31'h0, mem_we}, 32'h1);
    dbg_addr = 5'd14;
    #1 rst_n = 1'b0;
    #1;
    check("arst_mem_we", {31'h0, mem_we}, 32'h0);
    check("arst_in_ready", {31'h0, in_ready}, 32'h0);
    check("arst_x14", dbg_data, 32'h0);
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_alu_a", alu_a, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'h0, in_ready}, 32'h1);
    sweep_regs();

    // Random micro-ops against the model.
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] imm;
      op = 3'($urandom_range(0, 7));
      case (op)
        3'd2:       imm = $urandom_range(0, 31);
        3'd4, 3'd5: imm = $urandom_range(0, 255);
        default:    imm = $urandom;
      endcase
      run_instr(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), imm, 1'($urandom_range(0, 1)), lat, err, br);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequencing stage directly upstream of `ALU` and `Memory`. Accepts one LEGv8-style micro-instruction per handshake, reads operands from an internal 32×32 X-register file, and drives `ALUOp`/`A`/`B`/`imm` into `ALU`. It captures `Result` or `Memory.read_data` back into the register file and reports completion, plus the CBZ branch outcome. It replaces the hand-sequenced register array and ALU driving used in block-level benches.

## Interface
- `DATA_W`, 32: register, operand and memory data width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: micro-instruction present.
- `in_ready` output 1: unit can accept; reset 0, 1 only in IDLE.
- `in_op` input 3: issue opcode; `issue_op_t` in `alu_pkg`.
- `in_rd`, `in_rn`, `in_rm` input 5 each: destination/Rt and source register indices.
- `in_imm` input 32: immediate, shift amount, or byte offset.
- `alu_op` output 4: to `ALU.ALUOp`; reset 0.
- `alu_a`, `alu_b`, `alu_imm` output 32 each: to `ALU.A/B/imm`; reset 0.
- `alu_result` input 32: from `ALU.Result`, combinational.
- `mem_addr`, `mem_wdata` output 32: to `Memory.address/write_data`; reset 0.
- `mem_we` output 1: to `Memory.write_enable`; reset 0.
- `mem_rdata` input 32: from `Memory.read_data`, combinational.
- `done_valid` output 1: one-cycle completion pulse; reset 0.
- `done_err` output 1: qualifies `done_valid`; undefined opcode; reset 0.
- `branch_taken` output 1: CBZ result, valid with `done_valid`; reset 0.
- `dbg_addr` input 5, `dbg_data` output 32: combinational register peek for verification.

## Operation
- Issue ops: ADD, ADDI, LSL, SUB, LDUR, STUR, CBZ. Codes 7 and above are undefined.
- Operand mapping in EXEC:
  - ADD: `alu_op`=0000, A=X[rn], B=X[rm].
  - SUB: `alu_op`=0011, A=X[rn], B=X[rm].
  - ADDI: `alu_op`=0001, A=X[rn], imm=in_imm.
  - LSL: `alu_op`=0010, A=X[rn], B=in_imm.
  - LDUR and STUR: `alu_op`=0001, A=X[rn], imm=in_imm. The result is the byte address.
  - CBZ: no ALU use; `alu_*` hold their previous values.
- X31 always reads 0. Writes to X31 are discarded.
- Fields are latched at handshake. Operands are read from the register file during EXEC.
- All arithmetic is 32-bit and wraps modulo 2^32. There is no overflow or flag output.
- Writeback:
  - ALU ops write `alu_result` to X[rd] at the end of EXEC.
  - LDUR writes `mem_rdata` to X[rd] at the end of MEM.
  - STUR drives `mem_addr`=latched address, `mem_wdata`=X[rd], and `mem_we`=1 for exactly the MEM cycle.
  - LDUR drives `mem_addr` with `mem_we`=0.
- CBZ: `branch_taken` = (X[rd]==0). It is registered and presented in DONE.
- Undefined opcode: no register write, no memory access; `done_err`=1 in DONE.

## Timing
- States: IDLE, EXEC, MEM, DONE.
  - IDLE→EXEC when `in_valid && in_ready`.
  - EXEC→MEM for LDUR and STUR; EXEC→DONE otherwise.
  - MEM→DONE.
  - DONE→IDLE unconditionally.
- Latency from the handshake edge to the `done_valid` cycle: 2 cycles for ALU ops, CBZ and undefined ops; 3 cycles for LDUR and STUR.
- Throughput: one instruction per 3 cycles (ALU ops) or 4 cycles (memory ops).
- A register written in EXEC or MEM is visible on `dbg_data` in DONE and to the next instruction.
- `done_valid`, `done_err` and `branch_taken` are high only in DONE and return to 0 in IDLE.
- `in_ready` is 0 in EXEC, MEM and DONE. `in_valid` held during those states is ignored, not queued.
- `mem_we` is 0 in every state except MEM for STUR.
- Asynchronous reset at any point, including mid-STUR:
  - `mem_we` drops immediately and state returns to IDLE.
  - All X registers and outputs clear to 0.
  - The pending writeback is lost.

## Structure
- `alu_pkg`:
  - ALUOp constants ALU_ADD=4'b0000, ALU_ADDI=4'b0001, ALU_LSL=4'b0010, ALU_SUB=4'b0011.
  - `issue_op_t` with ADD=0, ADDI=1, LSL=2, SUB=3, LDUR=4, STUR=5, CBZ=6.
  - `issue_state_t`.
- Sub-module `x_regfile`:
  - 32×DATA_W, asynchronous active-low clear.
  - Three combinational read ports plus the debug port.
  - One synchronous write port.
  - X31 hardwired to zero.
- FSM, operand muxing and field latches live in `alu_issue_unit`.

## Test plan
- ADDI X6,X31,#20, then ADD X5,X31,X31 → `dbg_data`(X6)=20, X5=0. `done_valid` arrives 2 cycles after each handshake with `done_err`=0.
- With X5=3: LSL X10,X5,#3 → X10=24. Then SUB X14,X31,X10 → X14=0xFFFFFFE8 (wrap).
- STUR X14,[X15,#0] with X15=0x40 → `mem_we`=1 for exactly one cycle at `mem_addr`=0x40, `mem_wdata`=0xFFFFFFE8. A following LDUR X12,[X15,#0] → X12=0xFFFFFFE8 after 3 cycles.
- CBZ on X16=0 → `branch_taken`=1 with `done_valid`. CBZ on X16=5 → `branch_taken`=0. ADDI X31,X31,#7 → X31 still reads 0.
- Opcode 7 → `done_err`=1, no register change, `mem_we` stays 0. `in_valid` held high through EXEC/DONE → exactly one accept per IDLE.
- Assert `rst_n`=0 during the MEM cycle of a STUR → `mem_we` falls without waiting for `clk`. After release, all registers read 0 and `in_ready`=1.
